// File: rtl/addsub_pkg.sv
// Shared constants, stage-count derivation and per-stage flag record for addsub_pipe.
package addsub_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  // Flags carried alongside each stage's data: valid, slice carry-out, signed overflow.
  typedef struct packed {
    logic vld;
    logic cy;
    logic ov;
  } stage_flags_t;

  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
    if (chunk == 0 || width < chunk) return 1;
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB for overflow detection.
module addsub_chunk #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  assign {cout, s} = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
  // sum bit = a ^ b ^ carry-in, so the MSB's incoming carry is recoverable from the result
  assign cmsb = a[N-1] ^ b[N-1] ^ s[N-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor resolving CHUNK bits per stage, valid/ready on both sides.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

  if ((CHUNK == 0) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  stage_flags_t     fl_q   [STAGES];
  logic [WIDTH-1:0] psum_q [STAGES];
  logic [WIDTH-1:0] ar_q   [STAGES];
  logic [WIDTH-1:0] br_q   [STAGES];
  logic             advance;

  // The whole pipe moves as one; it only stalls when a finished result is not taken.
  assign advance  = !fl_q[STAGES-1].vld || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_vld;
    logic             src_cy;
    logic [WIDTH-1:0] src_psum;
    logic [WIDTH-1:0] src_ar;
    logic [WIDTH-1:0] src_br;
    logic [CHUNK-1:0] s;
    logic             cout;
    logic             cmsb;

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + ~borrow; inverting both here keeps every slice a plain adder.
      assign src_vld  = in_valid;
      assign src_cy   = ci ^ sub;
      assign src_psum = '0;
      assign src_ar   = a;
      assign src_br   = sub ? ~b : b;
    end else begin : g_body
      assign src_vld  = fl_q[k-1].vld;
      assign src_cy   = fl_q[k-1].cy;
      assign src_psum = psum_q[k-1];
      assign src_ar   = ar_q[k-1];
      assign src_br   = br_q[k-1];
    end

    addsub_chunk #(.N(CHUNK)) u_chunk (
      .a    (src_ar[CHUNK-1:0]),
      .b    (src_br[CHUNK-1:0]),
      .cin  (src_cy),
      .s    (s),
      .cout (cout),
      .cmsb (cmsb)
    );

    // Unprocessed operand slices shift down so the next stage always reads the low CHUNK bits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fl_q[k]   <= '0;
        psum_q[k] <= '0;
        ar_q[k]   <= '0;
        br_q[k]   <= '0;
      end else if (advance) begin
        fl_q[k]   <= '{vld: src_vld, cy: cout, ov: cout ^ cmsb};
        psum_q[k] <= src_psum | (WIDTH'(s) << (k * CHUNK));
        ar_q[k]   <= src_ar >> CHUNK;
        br_q[k]   <= src_br >> CHUNK;
      end
    end
  end

  assign out_valid = fl_q[STAGES-1].vld;
  assign sum       = psum_q[STAGES-1];
  assign co        = fl_q[STAGES-1].cy;
  assign ovf       = fl_q[STAGES-1].ov;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, CHUNK=4) against an integer-arithmetic reference.
module tb_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  addsub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic; returns {sum, co, ovf}.
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
    int ua, ub, sa, sb, ci_i, u, sr;
    logic carry, ov;
    ua   = int'(x);
    ub   = int'(y);
    sa   = int'($signed(x));
    sb   = int'($signed(y));
    ci_i = c ? 1 : 0;
    if (s) begin
      u     = ua - ub - ci_i;
      sr    = sa - sb - ci_i;
      carry = (u >= 0);
    end else begin
      u     = ua + ub + ci_i;
      sr    = sa + sb + ci_i;
      carry = (u > 65535);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {16'(u), carry, ov};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, sum, co, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b sum=%h co=%b ovf=%b ir=%b, want 0/0000/0/0/1",
               out_valid, sum, co, ovf, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Spec-listed vectors: one op at a time, latency and result checked against hand-derived constants.
  task automatic test_directed();
    logic [15:0] ta [7] = '{16'h0000, 16'hFFFF, 16'h0FFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
    logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
    logic        tc [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [17:0] te [7] = '{{16'h0002, 2'b00}, {16'h0000, 2'b10}, {16'h1000, 2'b00},
                            {16'h8000, 2'b01}, {16'h7FFF, 2'b11}, {16'hFFFE, 2'b00},
                            {16'hFFFD, 2'b00}};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = ta[i]; b = tb[i]; ci = tc[i]; sub = ts[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      n_cmp++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
      end
      n_cmp++;
      if ({sum, co, ovf} !== te[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
                 i, sum, co, ovf, te[i][17:2], te[i][1], te[i][0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Six back-to-back pushes with out_ready dropped for three cycles once the pipe is full.
  task automatic test_backpressure();
    logic [17:0] exp_q [$];
    logic [17:0] e, held;
    logic        was_stalled = 1'b0;
    int acc = 0, got = 0, cyc = 0;
    while ((acc < 6 || exp_q.size() > 0) && cyc < 100) begin
      in_valid  = (acc < 6);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      out_ready = !(cyc >= 5 && cyc < 8);
      #1;
      if (was_stalled) begin
        n_cmp++;
        if ({out_valid, sum, co, ovf} !== {1'b1, held}) begin
          n_err++;
          $display("FAIL bp_stable: got v=%b %h/%b/%b, want held %h/%b/%b",
                   out_valid, sum, co, ovf, held[17:2], held[1], held[0]);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_in_ready_stall: got %b, want 0", in_ready);
        end
      end
      was_stalled = out_valid && !out_ready;
      held = {sum, co, ovf};
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_unexpected: got result %h with nothing outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, co, ovf} !== e) begin
            n_err++;
            $display("FAIL bp_result[%0d]: got %h/%b/%b, want %h/%b/%b",
                     got, sum, co, ovf, e[17:2], e[1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(a, b, ci, sub));
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got !== 6 || acc !== 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d results for %0d pushes (%0d left), want 6/6/0",
               got, acc, exp_q.size());
    end
  endtask

  // Random valid/ready on both sides against the reference queue.
  task automatic test_random(input int n);
    logic [17:0] exp_q [$];
    logic [17:0] e;
    int acc = 0, got = 0, guard = 0;
    while ((acc < n || exp_q.size() > 0) && guard < 5000) begin
      in_valid  = (acc < n) && ($urandom_range(3) != 0);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      if ($urandom_range(7) == 0) a = 16'h7FFF;
      if ($urandom_range(7) == 0) b = 16'h8000;
      out_ready = ($urandom_range(2) != 0);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++;
        $display("FAIL rnd_in_ready: got %b, want %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_unexpected: got result %h with nothing outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, co, ovf} !== e) begin
            n_err++;
            $display("FAIL rnd_result[%0d]: got %h/%b/%b, want %h/%b/%b",
                     got, sum, co, ovf, e[17:2], e[1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(a, b, ci, sub));
        acc++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got !== n) begin
      n_err++;
      $display("FAIL rnd_count: got %0d results, want %0d", got, n);
    end
  endtask

  // Reset while three ops are in flight; nothing stale may emerge afterwards.
  task automatic test_reset_mid();
    logic [17:0] e;
    int lat, stale = 0, w = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom) | 16'h0101; b = 16'($urandom); ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, sum, co, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midreset_state: got ov=%b sum=%h co=%b ovf=%b ir=%b, want 0/0000/0/0/1",
               out_valid, sum, co, ovf, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin
      n_err++;
      $display("FAIL midreset_stale: got %0d stale valid cycles, want 0", stale);
    end
    a = 16'h1234; b = 16'h0FED; ci = 1'b1; sub = 1'b1; in_valid = 1'b1;
    e = ref_op(a, b, ci, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 4 || {sum, co, ovf} !== e) begin
      n_err++;
      $display("FAIL midreset_next: got lat=%0d %h/%b/%b, want lat=4 %h/%b/%b",
               lat, sum, co, ovf, e[17:2], e[1], e[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(200);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
